// File: rtl/vga16_pkg.sv
// Shared widths, the display-list entry type, RGB565 colours and clip limits.
// Clipping itself is only used when VECTOR_CLIP_EN is defined.
package vga16_pkg;

    localparam int COORD_W = 10;
    localparam int COL_W   = 16;

    localparam logic [COORD_W-1:0] H_MAX = 10'd639;
    localparam logic [COORD_W-1:0] V_MAX = 10'd479;

    localparam logic [COL_W-1:0] RED   = 16'hF800;
    localparam logic [COL_W-1:0] GREEN = 16'h07E0;
    localparam logic [COL_W-1:0] BLUE  = 16'h001F;

    typedef struct packed {
        logic [COORD_W-1:0] x0;
        logic [COORD_W-1:0] y0;
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] y1;
        logic [COL_W-1:0]   col;
        logic               last;
    } vector_t;

    typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} swap_state_t;

    function automatic logic [COORD_W-1:0] saturate(input logic [COORD_W-1:0] v,
                                                     input logic [COORD_W-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/vector_bank.sv
// One display-list bank: simple dual-port RAM, one write port, one registered read port.
module vector_bank
    import vga16_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  vector_t           wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output vector_t           rdata
);

    vector_t mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/vector_list.sv
// Double-buffered display list: host fills the back bank, line drawer reads the front,
// banks swap on vtrigger. Define VECTOR_CLIP_EN to saturate coordinates to H_MAX/V_MAX.
module vector_list
    import vga16_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [COORD_W-1:0] wr_x0,
    input  logic [COORD_W-1:0] wr_y0,
    input  logic [COORD_W-1:0] wr_x1,
    input  logic [COORD_W-1:0] wr_y1,
    input  logic [COL_W-1:0]   wr_col,
    input  logic               wr_last,
    output logic               wr_drop,
    input  logic               swap_req,
    output logic               swap_pending,
    output logic               front_sel,
    input  logic               vtrigger,
    input  logic               read_vector,
    input  logic [9:0]         vector_nr,
    output logic [COORD_W-1:0] x0,
    output logic [COORD_W-1:0] y0,
    output logic [COORD_W-1:0] x1,
    output logic [COORD_W-1:0] y1,
    output logic [COL_W-1:0]   col,
    output logic               last_vector
);

    swap_state_t state_reg, state_next;
    logic        front_sel_reg, front_sel_next;
    logic        front_valid_reg, front_valid_next;
    logic        wr_drop_reg;
    logic        zero_reg;
    logic        bank_reg;
    logic        wr_ok;
    logic        out_of_range;
    vector_t     wr_vec;
    vector_t     out_vec;
    vector_t     rd_data [2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            front_sel_reg   <= 1'b0;
            front_valid_reg <= 1'b0;
            wr_drop_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            front_sel_reg   <= front_sel_next;
            front_valid_reg <= front_valid_next;
            wr_drop_reg     <= wr_en && (state_reg == PENDING);
        end
    end

    // A request arriving together with vtrigger swaps immediately without visiting PENDING.
    always_comb begin
        state_next       = state_reg;
        front_sel_next   = front_sel_reg;
        front_valid_next = front_valid_reg;
        case (state_reg)
            IDLE: begin
                if (swap_req && vtrigger) begin
                    front_sel_next   = ~front_sel_reg;
                    front_valid_next = 1'b1;
                end else if (swap_req) begin
                    state_next = PENDING;
                end
            end
            PENDING: begin
                if (vtrigger) begin
                    state_next       = IDLE;
                    front_sel_next   = ~front_sel_reg;
                    front_valid_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign wr_ok = wr_en && (state_reg == IDLE);

    always_comb begin
        wr_vec.col  = wr_col;
        wr_vec.last = wr_last;
`ifdef VECTOR_CLIP_EN
        wr_vec.x0 = saturate(wr_x0, H_MAX);
        wr_vec.y0 = saturate(wr_y0, V_MAX);
        wr_vec.x1 = saturate(wr_x1, H_MAX);
        wr_vec.y1 = saturate(wr_y1, V_MAX);
`else
        wr_vec.x0 = wr_x0;
        wr_vec.y0 = wr_y0;
        wr_vec.x1 = wr_x1;
        wr_vec.y1 = wr_y1;
`endif
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            vector_bank #(.ADDR_W(ADDR_W)) u_bank (
                .clk   (clk),
                .we    (wr_ok && (front_sel_reg != gi[0])),
                .waddr (wr_addr),
                .wdata (wr_vec),
                .re    (read_vector),
                .raddr (vector_nr[ADDR_W-1:0]),
                .rdata (rd_data[gi])
            );
        end
    endgenerate

    assign out_of_range = ({22'd0, vector_nr} >> ADDR_W) != 32'd0;

    // Bank choice and empty/out-of-range masking are captured with the RAM read,
    // so a read on a swap edge still selects the pre-swap front bank.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            zero_reg <= 1'b1;
            bank_reg <= 1'b0;
        end else if (read_vector) begin
            zero_reg <= !front_valid_reg || out_of_range;
            bank_reg <= front_sel_reg;
        end
    end

    always_comb begin
        out_vec = rd_data[bank_reg];
        if (zero_reg) begin
            out_vec      = '0;
            out_vec.last = 1'b1;
        end
    end

    assign x0           = out_vec.x0;
    assign y0           = out_vec.y0;
    assign x1           = out_vec.x1;
    assign y1           = out_vec.y1;
    assign col          = out_vec.col;
    assign last_vector  = out_vec.last;
    assign wr_drop      = wr_drop_reg;
    assign swap_pending = (state_reg == PENDING);
    assign front_sel    = front_sel_reg;

endmodule

// File: tb/tb_vector_list.sv
// Directed bench for vector_list (ADDR_W=5): reset, swap, drop, same-cycle swap, range, clip.
module tb_vector_list;
    import vga16_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic               wr_en;
    logic [4:0]         wr_addr;
    logic [COORD_W-1:0] wr_x0, wr_y0, wr_x1, wr_y1;
    logic [COL_W-1:0]   wr_col;
    logic               wr_last;
    logic               wr_drop;
    logic               swap_req;
    logic               swap_pending;
    logic               front_sel;
    logic               vtrigger;
    logic               read_vector;
    logic [9:0]         vector_nr;
    logic [COORD_W-1:0] x0, y0, x1, y1;
    logic [COL_W-1:0]   col;
    logic               last_vector;

    int n_checks = 0;
    int n_fail   = 0;

    logic [56:0] obs;
    logic [56:0] expv;
    assign obs = {x0, y0, x1, y1, col, last_vector};

    vector_list #(.ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_x0(wr_x0), .wr_y0(wr_y0), .wr_x1(wr_x1), .wr_y1(wr_y1),
        .wr_col(wr_col), .wr_last(wr_last), .wr_drop(wr_drop),
        .swap_req(swap_req), .swap_pending(swap_pending), .front_sel(front_sel),
        .vtrigger(vtrigger), .read_vector(read_vector), .vector_nr(vector_nr),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .col(col), .last_vector(last_vector)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 0; swap_req = 0; vtrigger = 0; read_vector = 0;
    endtask

    task automatic write_entry(input logic [4:0] a, input logic [9:0] ax0, ay0, ax1, ay1,
                               input logic [15:0] c, input logic l);
        wr_en = 1; wr_addr = a; wr_x0 = ax0; wr_y0 = ay0; wr_x1 = ax1; wr_y1 = ay1;
        wr_col = c; wr_last = l;
        tick();
        wr_en = 0;
    endtask

    task automatic read_entry(input logic [9:0] n);
        read_vector = 1; vector_nr = n;
        tick();
        read_vector = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        wr_addr = 0; wr_x0 = 0; wr_y0 = 0; wr_x1 = 0; wr_y1 = 0; wr_col = 0; wr_last = 0;
        vector_nr = 0;
        reset = 0;
        #12;
        expv = {10'd0, 10'd0, 10'd0, 10'd0, 16'd0, 1'b1};
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL reset_outputs got %h want %h", obs, expv); end
        n_checks++;
        if ({front_sel, swap_pending, wr_drop} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags got %b want 000", {front_sel, swap_pending, wr_drop});
        end
        @(negedge clk);
        reset = 1;
        tick();
        read_entry(10'd0);
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL empty_front_read got %h want %h", obs, expv); end
        $display("test_reset done");
    endtask

    task automatic test_swap_basic();
        write_entry(5'd0, 10'd17, 10'd17, 10'd31, 10'd31, RED, 1'b1);
        swap_req = 1; tick(); swap_req = 0;
        n_checks++;
        if (swap_pending !== 1'b1) begin n_fail++; $display("FAIL pending_set got %b want 1", swap_pending); end
        vtrigger = 1; tick(); vtrigger = 0;
        n_checks++;
        if ({front_sel, swap_pending} !== 2'b10) begin
            n_fail++; $display("FAIL swap_done got %b want 10", {front_sel, swap_pending});
        end
        read_entry(10'd0);
        expv = {10'd17, 10'd17, 10'd31, 10'd31, 16'hF800, 1'b1};
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL read_after_swap got %h want %h", obs, expv); end
        $display("test_swap_basic done");
    endtask

    task automatic test_pending_drop();
        // front=1, back=bank0
        write_entry(5'd3, 10'd1, 10'd2, 10'd3, 10'd4, GREEN, 1'b0);
        swap_req = 1; tick(); swap_req = 0;
        write_entry(5'd3, 10'd9, 10'd9, 10'd9, 10'd9, BLUE, 1'b1);
        n_checks++;
        if (wr_drop !== 1'b1) begin n_fail++; $display("FAIL drop_pulse got %b want 1", wr_drop); end
        tick();
        n_checks++;
        if (wr_drop !== 1'b0) begin n_fail++; $display("FAIL drop_clears got %b want 0", wr_drop); end
        read_entry(10'd0);
        expv = {10'd17, 10'd17, 10'd31, 10'd31, 16'hF800, 1'b1};
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL old_front_while_pending got %h want %h", obs, expv); end
        // read on the swap edge sees the pre-swap bank
        read_vector = 1; vector_nr = 10'd0; vtrigger = 1; tick();
        read_vector = 0; vtrigger = 0;
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL read_on_swap_edge got %h want %h", obs, expv); end
        n_checks++;
        if ({front_sel, swap_pending} !== 2'b00) begin
            n_fail++; $display("FAIL swap_back got %b want 00", {front_sel, swap_pending});
        end
        read_entry(10'd3);
        expv = {10'd1, 10'd2, 10'd3, 10'd4, 16'h07E0, 1'b0};
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL dropped_write_absent got %h want %h", obs, expv); end
        $display("test_pending_drop done");
    endtask

    task automatic test_same_cycle();
        write_entry(5'd5, 10'd100, 10'd200, 10'd300, 10'd400, 16'h1234, 1'b1);
        swap_req = 1; vtrigger = 1; tick(); swap_req = 0; vtrigger = 0;
        n_checks++;
        if ({front_sel, swap_pending} !== 2'b10) begin
            n_fail++; $display("FAIL same_cycle_swap got %b want 10", {front_sel, swap_pending});
        end
        read_entry(10'd5);
        expv = {10'd100, 10'd200, 10'd300, 10'd400, 16'h1234, 1'b1};
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL same_cycle_read got %h want %h", obs, expv); end
        // outputs hold with read_vector low
        vector_nr = 10'd0; tick(); tick();
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL hold_no_read got %h want %h", obs, expv); end
        $display("test_same_cycle done");
    endtask

    task automatic test_out_of_range();
        read_entry(10'd32);
        expv = {10'd0, 10'd0, 10'd0, 10'd0, 16'd0, 1'b1};
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL out_of_range_32 got %h want %h", obs, expv); end
        read_entry(10'd5);
        read_entry(10'd1023);
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL out_of_range_1023 got %h want %h", obs, expv); end
        $display("test_out_of_range done");
    endtask

    task automatic test_clip();
        // front=1, back=bank0
        write_entry(5'd7, 10'd5, 10'd6, 10'd700, 10'd500, BLUE, 1'b0);
        swap_req = 1; vtrigger = 1; tick(); swap_req = 0; vtrigger = 0;
        read_entry(10'd7);
`ifdef VECTOR_CLIP_EN
        expv = {10'd5, 10'd6, 10'd639, 10'd479, 16'h001F, 1'b0};
`else
        expv = {10'd5, 10'd6, 10'd700, 10'd500, 16'h001F, 1'b0};
`endif
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL clip_read got %h want %h", obs, expv); end
        $display("test_clip done");
    endtask

    initial begin
        test_reset();
        test_swap_basic();
        test_pending_drop();
        test_same_cycle();
        test_out_of_range();
        test_clip();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
